sd_rx_pack_fifo: RTL and testbench

Receive-side data packer and FIFO for the SD controller data path. It accepts 1-bit or 4-bit samples from the SD DAT lines, packs them into WORD_W-bit words with selectable endianness, and stores them in a DEPTH-word single-clock FIFO read by the host/DMA side. This block is the parametrised successor of the fixed 4-bit/32-bit receive FIFO. It adds a runtime bus-width mode, a fill level, a sticky overflow flag, a flush, and a first-word-fall-through read port.

---
 rtl/sd_rx_pack_fifo.sv | 110 +++++++++++
 tb/tb_sd_rx_pack_fifo.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/sd_rx_pack_fifo.sv
// SD receive-path packer: assembles 1-bit or 4-bit DAT samples into WORD_W-bit words
// and queues them in a DEPTH-word first-word-fall-through FIFO.
module sd_rx_pack_fifo #(
  parameter int unsigned WORD_W     = 32,
  parameter int unsigned DEPTH      = 8,
  parameter bit          BIG_ENDIAN = 1'b0,
  localparam int unsigned ADR_W     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wide,
  input  logic [3:0]        d,
  input  logic              wr,
  input  logic              flush,
  input  logic              rd,
  output logic [WORD_W-1:0] q,
  output logic              empty,
  output logic              full,
  output logic [ADR_W:0]    level,
  output logic              pend,
  output logic              ovf
);

  localparam int unsigned CNT_W = $clog2(WORD_W);
  localparam int unsigned SH_W  = $clog2(WORD_W) + 1;

  logic [WORD_W-1:0] mem [DEPTH];

  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_base, last_idx;
  logic [WORD_W-1:0] sreg_q, sreg_d, sreg_base, samp, word_c;
  logic [ADR_W:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic              ovf_q, ovf_d;
  logic              wide_q, wide_d;
  logic [SH_W-1:0]   off, sh;
  logic              clr, word_done, pop, push_ok;

  assign clr   = rst | flush;
  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[ADR_W-1:0] == rptr_q[ADR_W-1:0]) && (wptr_q[ADR_W] != rptr_q[ADR_W]);
  assign level = wptr_q - rptr_q;
  assign pend  = (cnt_q != '0);
  assign ovf   = ovf_q;
  assign q     = mem[rptr_q[ADR_W-1:0]];

  // Packer datapath: a width change restarts the word, so the partial one is lost.
  always_comb begin
    cnt_base  = (wide != wide_q) ? '0 : cnt_q;
    sreg_base = (cnt_base == '0) ? '0 : sreg_q;
    last_idx  = wide ? CNT_W'(WORD_W / 4 - 1) : CNT_W'(WORD_W - 1);
    samp      = wide ? WORD_W'(d) : WORD_W'(d[0]);
    off       = wide ? (SH_W'(cnt_base) << 2) : SH_W'(cnt_base);
    sh        = BIG_ENDIAN ? (SH_W'(WORD_W) - (wide ? SH_W'(4) : SH_W'(1)) - off) : off;
    word_c    = sreg_base | (samp << sh);
    word_done = wr && (cnt_base == last_idx);
    pop       = rd && !empty;
    push_ok   = word_done && (!full || pop);
  end

  // Next-state for packer, pointers and overflow flag; clear wins over everything.
  always_comb begin
    cnt_d  = cnt_base;
    sreg_d = sreg_base;
    wptr_d = wptr_q + (ADR_W + 1)'(push_ok);
    rptr_d = rptr_q + (ADR_W + 1)'(pop);
    ovf_d  = ovf_q | (word_done && full && !pop);
    wide_d = wide;
    if (wr) begin
      if (word_done) begin
        cnt_d  = '0;
        sreg_d = '0;
      end else begin
        cnt_d  = cnt_base + CNT_W'(1);
        sreg_d = word_c;
      end
    end
    if (clr) begin
      cnt_d  = '0;
      sreg_d = '0;
      wptr_d = '0;
      rptr_d = '0;
      ovf_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      sreg_q <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      ovf_q  <= 1'b0;
      wide_q <= wide;
    end else begin
      cnt_q  <= cnt_d;
      sreg_q <= sreg_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      ovf_q  <= ovf_d;
      wide_q <= wide_d;
    end
  end

  // Storage array, intentionally not reset.
  always_ff @(posedge clk) begin
    if (push_ok && !clr) begin
      mem[wptr_q[ADR_W-1:0]] <= word_c;
    end
  end

endmodule

// File: tb/tb_sd_rx_pack_fifo.sv
// Self-checking bench for sd_rx_pack_fifo: LE and BE instances driven in parallel,
// compared every cycle against a queue-based model plus literal spot checks.
module tb_sd_rx_pack_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1, wide = 1'b1, wr = 1'b0, flush = 1'b0, rd = 1'b0;
  logic [3:0] d = 4'h0;

  logic [31:0] q_le, q_be;
  logic        empty_le, full_le, pend_le, ovf_le;
  logic        empty_be, full_be, pend_be, ovf_be;
  logic [2:0]  level_le, level_be;

  sd_rx_pack_fifo #(.WORD_W(32), .DEPTH(4), .BIG_ENDIAN(1'b0)) u_le (
    .clk(clk), .rst(rst), .wide(wide), .d(d), .wr(wr), .flush(flush), .rd(rd),
    .q(q_le), .empty(empty_le), .full(full_le), .level(level_le), .pend(pend_le), .ovf(ovf_le));

  sd_rx_pack_fifo #(.WORD_W(32), .DEPTH(4), .BIG_ENDIAN(1'b1)) u_be (
    .clk(clk), .rst(rst), .wide(wide), .d(d), .wr(wr), .flush(flush), .rd(rd),
    .q(q_be), .empty(empty_be), .full(full_be), .level(level_be), .pend(pend_be), .ovf(ovf_be));

  // Model state: samples of the word in progress and the stored words per endianness.
  logic [3:0]  m_samp[$];
  logic [31:0] m_fifo_le[$];
  logic [31:0] m_fifo_be[$];
  bit          m_ovf;
  logic        m_prev_wide;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit          pop;
    int          s;
    logic [31:0] wl, wb;
    if (rst || flush) begin
      m_samp.delete();
      m_fifo_le.delete();
      m_fifo_be.delete();
      m_ovf       = 1'b0;
      m_prev_wide = wide;
      return;
    end
    if (wide != m_prev_wide) m_samp.delete();
    m_prev_wide = wide;
    pop = rd && (m_fifo_le.size() > 0);
    if (pop) begin
      void'(m_fifo_le.pop_front());
      void'(m_fifo_be.pop_front());
    end
    if (wr) begin
      s = wide ? 4 : 1;
      m_samp.push_back(wide ? d : {3'b000, d[0]});
      if (m_samp.size() * s == 32) begin
        wl = '0;
        wb = '0;
        for (int k = 0; k < m_samp.size(); k++) begin
          wl |= 32'(m_samp[k]) << (k * s);
          wb |= 32'(m_samp[k]) << (32 - s - k * s);
        end
        if (m_fifo_le.size() < 4) begin
          m_fifo_le.push_back(wl);
          m_fifo_be.push_back(wb);
        end else begin
          m_ovf = 1'b1;
        end
        m_samp.delete();
      end
    end
  endtask

  task automatic check_outputs();
    chk("le.empty", 32'(empty_le), 32'(m_fifo_le.size() == 0));
    chk("le.full",  32'(full_le),  32'(m_fifo_le.size() == 4));
    chk("le.level", 32'(level_le), 32'(m_fifo_le.size()));
    chk("le.pend",  32'(pend_le),  32'(m_samp.size() != 0));
    chk("le.ovf",   32'(ovf_le),   32'(m_ovf));
    chk("be.empty", 32'(empty_be), 32'(m_fifo_be.size() == 0));
    chk("be.level", 32'(level_be), 32'(m_fifo_be.size()));
    chk("be.ovf",   32'(ovf_be),   32'(m_ovf));
    if (m_fifo_le.size() > 0) begin
      chk("le.q", q_le, m_fifo_le[0]);
      chk("be.q", q_be, m_fifo_be[0]);
    end
  endtask

  task automatic cyc(input logic w, input logic [3:0] dd, input logic r, input logic f, input logic rs);
    wr = w; d = dd; rd = r; flush = f; rst = rs;
    model_edge();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  // One 4-bit-mode word whose LE image is v; optional rd on first/last sample cycle.
  task automatic push_word(input logic [31:0] v, input logic r_first, input logic r_last);
    for (int i = 0; i < 8; i++)
      cyc(1'b1, v[4*i +: 4], (i == 0) ? r_first : ((i == 7) ? r_last : 1'b0), 1'b0, 1'b0);
  endtask

  task automatic pop_expect(input string name, input logic [31:0] exp);
    chk(name, q_le, exp);
    cyc(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic bit_word(input bit gaps);
    for (int i = 0; i < 32; i++) begin
      if (gaps && (i == 5 || i == 17)) cyc(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, {3'b000, 1'(i % 2 == 0)}, 1'b0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    m_prev_wide = 1'b1;
    cyc(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
    chk("rst.empty", 32'(empty_le), 32'd1);
    chk("rst.level", 32'(level_le), 32'd0);
    chk("rst.pend",  32'(pend_le),  32'd0);
    cyc(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);

    // Nibbles 1..8
    push_word(32'h8765_4321, 1'b0, 1'b0);
    chk("nib.q_le",  q_le, 32'h8765_4321);
    chk("nib.q_be",  q_be, 32'h1234_5678);
    chk("nib.level", 32'(level_le), 32'd1);
    chk("nib.pend",  32'(pend_le), 32'd0);
    cyc(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);

    // 1-bit mode, contiguous and with gaps
    wide = 1'b0;
    bit_word(1'b0);
    chk("bit.q_le", q_le, 32'h5555_5555);
    chk("bit.q_be", q_be, 32'hAAAA_AAAA);
    cyc(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    bit_word(1'b1);
    chk("gap.q_le",  q_le, 32'h5555_5555);
    chk("gap.level", 32'(level_le), 32'd1);
    cyc(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    wide = 1'b1;

    // Fill, overflow, drain
    push_word(32'hA1A2_A3A4, 1'b0, 1'b0);
    push_word(32'hB1B2_B3B4, 1'b0, 1'b0);
    push_word(32'hC1C2_C3C4, 1'b0, 1'b0);
    push_word(32'hD1D2_D3D4, 1'b0, 1'b0);
    chk("fill.full",  32'(full_le),  32'd1);
    chk("fill.level", 32'(level_le), 32'd4);
    push_word(32'hE1E2_E3E4, 1'b0, 1'b0);
    chk("ovf.flag",  32'(ovf_le),   32'd1);
    chk("ovf.level", 32'(level_le), 32'd4);
    pop_expect("ovf.pop0", 32'hA1A2_A3A4);
    pop_expect("ovf.pop1", 32'hB1B2_B3B4);
    pop_expect("ovf.pop2", 32'hC1C2_C3C4);
    pop_expect("ovf.pop3", 32'hD1D2_D3D4);
    chk("ovf.empty", 32'(empty_le), 32'd1);
    chk("ovf.sticky", 32'(ovf_le), 32'd1);
    cyc(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
    chk("flush.ovf", 32'(ovf_le), 32'd0);

    // Complete a word on the same edge as a pop while full
    push_word(32'hF1F1_F1F1, 1'b0, 1'b0);
    push_word(32'hF2F2_F2F2, 1'b0, 1'b0);
    push_word(32'hF3F3_F3F3, 1'b0, 1'b0);
    push_word(32'hF4F4_F4F4, 1'b0, 1'b0);
    push_word(32'h6060_6060, 1'b0, 1'b1);
    chk("rdwr.level", 32'(level_le), 32'd4);
    chk("rdwr.ovf",   32'(ovf_le),   32'd0);
    pop_expect("rdwr.pop0", 32'hF2F2_F2F2);
    pop_expect("rdwr.pop1", 32'hF3F3_F3F3);
    pop_expect("rdwr.pop2", 32'hF4F4_F4F4);
    pop_expect("rdwr.pop3", 32'h6060_6060);

    // Interleaved traffic wrapping the pointers
    for (int i = 0; i < 10; i++)
      push_word(32'hC000_0000 + 32'(i), (i % 2 == 1) || (i >= 6), 1'b0);
    push_word(32'hC000_00FF, 1'b0, 1'b0);
    chk("wrap.full", 32'(full_le), 32'd1);
    for (int i = 0; i < 5; i++) cyc(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    chk("wrap.empty", 32'(empty_le), 32'd1);

    // Partial word discarded by rst, then by flush
    for (int i = 0; i < 3; i++) cyc(1'b1, 4'(i + 3), 1'b0, 1'b0, 1'b0);
    chk("part.pend", 32'(pend_le), 32'd1);
    cyc(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
    chk("rstp.pend", 32'(pend_le), 32'd0);
    push_word(32'h2345_6789, 1'b0, 1'b1);
    chk("rstp.q_le", q_le, 32'h2345_6789);
    chk("rstp.q_be", q_be, 32'h9876_5432);
    chk("rstp.level", 32'(level_le), 32'd1);
    cyc(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 4'(i + 10), 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
    chk("flp.pend", 32'(pend_le), 32'd0);
    push_word(32'h2345_6789, 1'b0, 1'b0);
    chk("flp.q_le", q_le, 32'h2345_6789);
    cyc(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
